word_serializer: RTL
====================

// Module: word_serializer
// PURPOSE
//  Parallel-to-serial feeder for the 16-bit serial-in shift/capture stage.
//  Accepts words over a valid/ready handshake, buffers one word, and drives
//  sout/sout_en MSB-first, exactly WIDTH enabled bits per word. After WIDTH
//  enables, the downstream register presents the word unchanged on its
//  parallel output. Back-to-back words stream with no idle cycle.
// PARAMETERS
//  WIDTH  16  word width; bits sent per word; must match downstream width
//  CNT_W  4   bit-counter width, = clog2(WIDTH)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  din        in   WIDTH  word to transmit
//  din_valid  in   1      din is valid
//  din_ready  out  1      word accepted on edge where din_valid & din_ready
//  sout       out  1      serial data, MSB of current word first
//  sout_en    out  1      sout carries a valid bit this cycle (drives shifter enable)
//  frame_start out 1      high with the first (MSB) bit of each word
//  word_done  out  1      high with the last (LSB) bit of each word
//  busy       out  1      engine in SHIFT or holding register full
// BEHAVIOUR
//  Reset: state IDLE, shreg=0, hold empty, bit_cnt=0; sout, sout_en, frame_start,
//   word_done, busy all 0; din_ready forced 0 while reset is high.
//  State: shreg[WIDTH-1:0], bit_cnt[CNT_W-1:0], hold[WIDTH-1:0] + hold_full.
//  FSM IDLE: sout_en=0, sout=0. SHIFT: sout_en=1, sout=shreg[WIDTH-1].
//  din_ready = ~hold_full & ~reset (combinational from registered state).
//  load_slot = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1).
//  At load_slot edge: if hold_full -> shreg<=hold, hold empties, SHIFT, bit_cnt<=0;
//   else if accept -> shreg<=din directly (bypass), SHIFT, bit_cnt<=0;
//   else -> IDLE.
//  Accept outside load_slot, or at load_slot while hold_full -> din goes to hold.
//  In SHIFT, not last bit: shreg<=shreg<<1 (LSB fill 0), bit_cnt<=bit_cnt+1.
//  Latency: word accepted at edge N (engine idle) -> MSB on sout in cycle N+1;
//   LSB in cycle N+WIDTH.
//  frame_start = SHIFT & bit_cnt==0; word_done = SHIFT & bit_cnt==WIDTH-1.
//  Gapless: hold_full at last bit -> next MSB immediately follows previous LSB.
//  Full: hold_full -> din_ready=0; din/din_valid ignored; no word is dropped.
//  Empty: no word at last bit -> IDLE next cycle, sout_en=0.
//  bit_cnt does not wrap: it is reset to 0 on every load and never passes WIDTH-1.
//  Reset mid-word: shreg and hold are discarded; outputs at reset values on the
//   next edge. The downstream stage must share this reset to keep its
//   16-enable framing aligned.
//  sout is 0 whenever sout_en=0.
// STRUCTURE
//  Shared package: WIDTH/CNT_W defaults and the state enum {IDLE, SHIFT}.
//  Single module, no sub-modules. The hold buffer is inline (1 entry).
//  Expected size is about 150 lines.
// TESTING
//  1 Single word 16'hA5C3 from idle -> sout_en high for 16 cycles; sout =
//    1010_0101_1100_0011; frame_start on cycle 1; word_done on cycle 16;
//    then IDLE.
//  2 Words 16'h0001, 16'h8000, 16'hFFFF, din_valid held -> 48 contiguous
//    sout_en cycles, no gap; din_ready drops while hold is full.
//  3 Backpressure: offer a word while shifting and hold full -> din_ready=0;
//    din changes while blocked are not sent; the stalled word is sent intact.
//  4 Reset asserted during bit 7 of 16'h1234 -> next cycle sout_en=0, busy=0,
//    din_ready=0 during reset; a new word 16'h00FF after release sends cleanly.
//  5 Chained with downstream shifter, same clk/reset: send 16'hBEEF, 16'h0F0F ->
//    shifter parallel output shows 16'hBEEF, then 16'h0F0F, one word per 16 enables.
//  6 Idle gap of 5 cycles between words -> sout_en=0 and sout=0 throughout the
//    gap; frame_start on the first bit of the second word.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: default geometry and the engine state type.
package word_serializer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready, keeps one spare word in a
// hold buffer and shifts each word out MSB-first as exactly WIDTH enabled bits.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             frame_start,
  output logic             word_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             last_bit;
  logic             load_slot;

  // Ready only depends on registered hold state, so no combinational path from din_valid.
  assign din_ready = ~hold_full & ~reset;
  assign accept    = din_valid & din_ready;
  assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign load_slot = (state == IDLE) || last_bit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load_slot) state_next = (hold_full || accept) ? SHIFT : IDLE;
  end

  // A held word always wins the load slot; otherwise an incoming word bypasses the hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
    end else if (load_slot) begin
      if (hold_full) begin
        shreg     <= hold;
        hold_full <= 1'b0;
        bit_cnt   <= '0;
      end else if (accept) begin
        shreg   <= din;
        bit_cnt <= '0;
      end
    end else begin
      shreg   <= {shreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    sout        = 1'b0;
    sout_en     = 1'b0;
    frame_start = 1'b0;
    word_done   = 1'b0;
    busy        = hold_full;
    if (state == SHIFT) begin
      sout        = shreg[WIDTH-1];
      sout_en     = 1'b1;
      frame_start = (bit_cnt == '0);
      word_done   = last_bit;
      busy        = 1'b1;
    end
  end

endmodule
